// File: rtl/dm_cache_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_cache_sequencer_pkg                                             |
// | Geometry constants, sequencer state encoding and address helper.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package dm_cache_sequencer_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK;
  localparam int NUM_BLOCKS      = 64;
  localparam int TAG_WIDTH       = 24;
  localparam int INDEX_WIDTH     = 6;
  localparam int OFFSET_WIDTH    = 2;
  localparam int ADDR_WIDTH      = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;
  localparam int BLK_ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOOKUP     = 3'd1,
    CHECK      = 3'd2,
    WRITE_BACK = 3'd3,
    FETCH      = 3'd4,
    REFILL     = 3'd5,
    RESPOND    = 3'd6
  } seq_state_t;

  function automatic logic [BLK_ADDR_WIDTH-1:0] blk_addr(
    input logic [TAG_WIDTH-1:0]   t,
    input logic [INDEX_WIDTH-1:0] i
  );
    return {t, i};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_cache_sequencer_if                                              |
// | CPU, cache_memory and main-memory signals of the miss sequencer.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface dm_cache_sequencer_if;
  import dm_cache_sequencer_pkg::*;

  logic                      cpu_req_valid;
  logic                      cpu_req_ready;
  logic                      cpu_req_type;
  logic [ADDR_WIDTH-1:0]     cpu_addr;
  logic [WORD_SIZE-1:0]      cpu_wdata;
  logic                      cpu_resp_valid;
  logic [WORD_SIZE-1:0]      cpu_rdata;

  logic [TAG_WIDTH-1:0]      tag;
  logic [INDEX_WIDTH-1:0]    index;
  logic [OFFSET_WIDTH-1:0]   blk_offset;
  logic                      req_type;
  logic                      read_en_cache;
  logic                      write_en_cache;
  logic                      refill;
  logic [WORD_SIZE-1:0]      data_in;
  logic [BLOCK_SIZE-1:0]     data_in_mem;
  logic                      hit;
  logic                      dirty_bit;
  logic [WORD_SIZE-1:0]      data_out;
  logic [BLOCK_SIZE-1:0]     dirty_block_out;
  logic                      done_cache;

  logic                      mem_req_valid;
  logic                      mem_we;
  logic [BLK_ADDR_WIDTH-1:0] mem_addr;
  logic [BLOCK_SIZE-1:0]     mem_wdata;
  logic                      mem_ack;
  logic [BLOCK_SIZE-1:0]     mem_rdata;

  logic                      err;

  // slave: the sequencer itself
  modport slave (
    input  cpu_req_valid, cpu_req_type, cpu_addr, cpu_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata,
    output tag, index, blk_offset, req_type, read_en_cache, write_en_cache,
    output refill, data_in, data_in_mem,
    input  hit, dirty_bit, data_out, dirty_block_out, done_cache,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output err
  );

  // master: CPU, cache_memory and main memory around the sequencer
  modport master (
    output cpu_req_valid, cpu_req_type, cpu_addr, cpu_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
    input  tag, index, blk_offset, req_type, read_en_cache, write_en_cache,
    input  refill, data_in, data_in_mem,
    output hit, dirty_bit, data_out, dirty_block_out, done_cache,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  err
  );

endinterface
`default_nettype wire

// File: rtl/dm_cache_sequencer_victim_tag_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_cache_sequencer_victim_tag_store                                |
// | Shadow tag per line; sync write, combinational read by index.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dm_cache_sequencer_victim_tag_store
  import dm_cache_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] idx,
  input  logic [TAG_WIDTH-1:0]   wtag,
  output logic [TAG_WIDTH-1:0]   rtag
);

  // Deliberately not reset: contents only matter for lines already refilled.
  logic [TAG_WIDTH-1:0] r_tags [NUM_BLOCKS];

  always_ff @(posedge clk) begin
    if (we) begin
      r_tags[idx] <= wtag;
    end
  end

  assign rtag = r_tags[idx];

endmodule
`default_nettype wire

// File: rtl/dm_cache_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_cache_sequencer                                                 |
// | Write-back / write-allocate miss sequencer for a direct-mapped     |
// | cache_memory array with a block-wide main-memory port.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dm_cache_sequencer
  import dm_cache_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dm_cache_sequencer_if.slave bus
);

  seq_state_t              r_state;
  seq_state_t              w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_type;
  logic [WORD_SIZE-1:0]    r_wdata;
  logic [WORD_SIZE-1:0]    r_rdata;
  logic [BLOCK_SIZE-1:0]   r_wb_blk;
  logic [BLOCK_SIZE-1:0]   r_fill_blk;
  logic                    r_replay;
  logic                    r_err;

  logic [TAG_WIDTH-1:0]    w_tag;
  logic [INDEX_WIDTH-1:0]  w_index;
  logic [OFFSET_WIDTH-1:0] w_offset;
  logic [TAG_WIDTH-1:0]    w_victim_tag;
  logic                    w_unused;

  assign w_tag    = r_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_index  = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_offset = r_addr[OFFSET_WIDTH-1:0];
  assign w_unused = bus.done_cache;

  dm_cache_sequencer_victim_tag_store u_victim_tags (
    .clk  (clk),
    .we   (r_state == REFILL),
    .idx  (w_index),
    .wtag (w_tag),
    .rtag (w_victim_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (bus.cpu_req_valid) w_next = LOOKUP;
      LOOKUP:     w_next = CHECK;
      CHECK: begin
        // A miss on the replay pass means the refill did not stick: give up.
        if (bus.hit || r_replay) w_next = RESPOND;
        else if (bus.dirty_bit)  w_next = WRITE_BACK;
        else                     w_next = FETCH;
      end
      WRITE_BACK: if (bus.mem_ack) w_next = FETCH;
      FETCH:      if (bus.mem_ack) w_next = REFILL;
      REFILL:     w_next = LOOKUP;
      RESPOND:    w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_type     <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wb_blk   <= '0;
      r_fill_blk <= '0;
      r_replay   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            r_addr  <= bus.cpu_addr;
            r_type  <= bus.cpu_req_type;
            r_wdata <= bus.cpu_wdata;
          end
        end
        CHECK: begin
          if (bus.hit) begin
            if (!r_type) r_rdata <= bus.data_out;
          end else if (r_replay) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else if (bus.dirty_bit) begin
            r_wb_blk <= bus.dirty_block_out;
          end
        end
        FETCH:   if (bus.mem_ack) r_fill_blk <= bus.mem_rdata;
        REFILL:  r_replay <= 1'b1;
        RESPOND: r_replay <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cpu_req_ready  = 1'b0;
    bus.read_en_cache  = 1'b0;
    bus.write_en_cache = 1'b0;
    bus.refill         = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_we         = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    case (r_state)
      IDLE:       bus.cpu_req_ready = 1'b1;
      LOOKUP: begin
        bus.read_en_cache  = ~r_type;
        bus.write_en_cache = r_type;
      end
      WRITE_BACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = 1'b1;
      end
      FETCH:      bus.mem_req_valid = 1'b1;
      REFILL: begin
        bus.refill         = 1'b1;
        bus.write_en_cache = 1'b1;
      end
      RESPOND:    bus.cpu_resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.tag         = w_tag;
  assign bus.index       = w_index;
  assign bus.blk_offset  = w_offset;
  assign bus.req_type    = r_type;
  assign bus.data_in     = r_wdata;
  assign bus.data_in_mem = r_fill_blk;
  assign bus.mem_wdata   = r_wb_blk;
  assign bus.mem_addr    = (r_state == WRITE_BACK) ? blk_addr(w_victim_tag, w_index)
                                                   : blk_addr(w_tag, w_index);
  assign bus.cpu_rdata   = r_rdata;
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dm_cache_sequencer                                              |
// | Scoreboard bench with behavioural cache_memory and memory models.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_dm_cache_sequencer;
  import dm_cache_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  dm_cache_sequencer_if bus();

  dm_cache_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    int          lat;
    logic        err;
    int          acc;
  } resp_t;

  typedef struct {
    logic          we;
    logic [29:0]   addr;
    logic [127:0]  wdata;
    logic [127:0]  rdata;
  } mem_t;

  resp_t sb[$];
  mem_t  mq[$];

  logic [127:0] c_data  [64];
  logic [23:0]  c_tag   [64];
  logic         c_valid [64];
  logic         c_dirty [64];
  logic         force_miss = 1'b0;
  logic [127:0] last_fill = '0;
  int           mem_delay = 0;
  int           wait_cnt  = 0;
  int           both_en   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // cache_memory model: lookup results valid from mid-enable cycle onwards
  always @(negedge clk) begin : cache_model
    logic h;
    if (bus.read_en_cache && bus.write_en_cache && !bus.refill) both_en++;
    if (bus.refill) begin
      check_val("refill_blk", bus.data_in_mem, last_fill);
      check_val("refill_we", bus.write_en_cache, 1);
      c_data[bus.index]  = bus.data_in_mem;
      c_tag[bus.index]   = bus.tag;
      c_valid[bus.index] = 1'b1;
      c_dirty[bus.index] = 1'b0;
    end else if (bus.read_en_cache || bus.write_en_cache) begin
      h = !force_miss && c_valid[bus.index] && (c_tag[bus.index] == bus.tag);
      bus.hit             = h;
      bus.dirty_bit       = c_dirty[bus.index];
      bus.dirty_block_out = c_data[bus.index];
      bus.data_out        = c_data[bus.index][bus.blk_offset*32 +: 32];
      if (bus.write_en_cache && h) begin
        c_data[bus.index][bus.blk_offset*32 +: 32] = bus.data_in;
        c_dirty[bus.index] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : mem_model
    bus.mem_ack = 1'b0;
    if (rst) begin
      wait_cnt = 0;
    end else if (bus.mem_req_valid) begin
      if (mq.size() == 0) begin
        check_val("unexpected_mem", 1, 0);
      end else begin
        check_val("mem_we", bus.mem_we, mq[0].we);
        check_val("mem_addr", bus.mem_addr, mq[0].addr);
        if (mq[0].we) check_val("mem_wdata", bus.mem_wdata, mq[0].wdata);
        if (wait_cnt >= mem_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mq[0].rdata;
          if (!mq[0].we) last_fill = mq[0].rdata;
          void'(mq.pop_front());
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin : resp_mon
    resp_t e;
    if (bus.cpu_resp_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_resp", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("latency", cyc - e.acc, e.lat);
        check_val("resp_err", bus.err, e.err);
        if (e.chk_rdata) check_val("rdata", bus.cpu_rdata, e.rdata);
      end
    end
  end

  task automatic push_mem(input logic we, input logic [23:0] t, input logic [5:0] i,
                          input logic [127:0] wd, input logic [127:0] rd);
    mem_t m;
    m.we = we; m.addr = {t, i}; m.wdata = wd; m.rdata = rd;
    mq.push_back(m);
  endtask

  // Request is held one extra cycle with scrambled fields; a busy sequencer must ignore it.
  task automatic do_req(input logic typ, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic chk_rd, input int lat,
                        input logic exp_err);
    resp_t e;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_type  = typ;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wd;
    e.rdata = exp_rd; e.chk_rdata = chk_rd; e.lat = lat; e.err = exp_err; e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.cpu_req_type  = ~typ;
    bus.cpu_addr      = ~addr;
    bus.cpu_wdata     = ~wd;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !bus.cpu_req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, bus.cpu_req_ready, 1);
    check_val({tag, "_ctl"},
              {bus.read_en_cache, bus.write_en_cache, bus.refill, bus.mem_req_valid,
               bus.mem_we, bus.cpu_resp_valid, bus.err, bus.mem_addr, bus.cpu_rdata}, 0);
    check_val({tag, "_req"}, {bus.tag, bus.index, bus.blk_offset, bus.req_type, bus.data_in}, 0);
    check_val({tag, "_wb"}, bus.mem_wdata, 0);
    check_val({tag, "_fill"}, bus.data_in_mem, 0);
  endtask

  logic [127:0] blk2, blk3_old, blk3_mod, blk3_new, blk5, blk6;

  initial begin
    rst = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_type  = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    bus.done_cache    = 1'b0;
    blk2     = 128'h44444444_33333333_22222222_1111F0F0;
    blk3_old = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    blk3_new = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    blk5     = 128'h55555555_55555555_55555555_55555555;
    blk6     = 128'h66666666_66666666_66666666_12345678;
    for (int i = 0; i < 64; i++) begin
      c_data[i] = '0; c_tag[i] = '0; c_valid[i] = 1'b0; c_dirty[i] = 1'b0;
    end
    c_valid[0] = 1'b1; c_tag[0] = 24'hABCDE0;
    c_data[0]  = 128'hDEADBEEF_00000002_00000001_00000000;
    c_valid[1] = 1'b1; c_tag[1] = 24'h000ABC;
    c_data[1]  = 128'h13131313_12121212_11111111_10101010;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // read hit
    do_req(1'b0, {24'hABCDE0, 6'd0, 2'd3}, 32'h0, 32'hDEADBEEF, 1'b1, 3, 1'b0);
    wait_done();

    // write hit
    do_req(1'b1, {24'h000ABC, 6'd1, 2'd3}, 32'hCAFEBABE, 32'h0, 1'b0, 3, 1'b0);
    wait_done();
    check_val("wr_hit_word", c_data[1][127:96], 32'hCAFEBABE);
    check_val("wr_hit_dirty", c_dirty[1], 1);

    // clean read miss: LOOKUP, CHECK, FETCH, REFILL, LOOKUP, CHECK, then RESPOND
    push_mem(1'b0, 24'h1A2B3C, 6'd2, '0, blk2);
    do_req(1'b0, {24'h1A2B3C, 6'd2, 2'd0}, 32'h0, blk2[31:0], 1'b1, 7, 1'b0);
    wait_done();
    check_val("clean_miss_mem_drained", mq.size(), 0);

    // bring tag D77000 into line 3 through the sequencer, then dirty it
    push_mem(1'b0, 24'hD77000, 6'd3, '0, blk3_old);
    do_req(1'b0, {24'hD77000, 6'd3, 2'd0}, 32'h0, blk3_old[31:0], 1'b1, 7, 1'b0);
    wait_done();
    do_req(1'b1, {24'hD77000, 6'd3, 2'd1}, 32'h5555AAAA, 32'h0, 1'b0, 3, 1'b0);
    wait_done();
    blk3_mod = blk3_old;
    blk3_mod[63:32] = 32'h5555AAAA;

    // dirty write miss: write-back of the victim, then fetch
    push_mem(1'b1, 24'hD77000, 6'd3, blk3_mod, '0);
    push_mem(1'b0, 24'h3C3C3C, 6'd3, '0, blk3_new);
    do_req(1'b1, {24'h3C3C3C, 6'd3, 2'd2}, 32'h77778888, 32'h0, 1'b0, 8, 1'b0);
    wait_done();
    check_val("dirty_miss_tag", c_tag[3], 24'h3C3C3C);
    check_val("dirty_miss_word", c_data[3][95:64], 32'h77778888);
    check_val("dirty_miss_dirty", c_dirty[3], 1);
    check_val("dirty_miss_mem_drained", mq.size(), 0);

    // stalled fetch interrupted by reset
    mem_delay = 1000;
    push_mem(1'b0, 24'h055555, 6'd5, '0, blk5);
    do_req(1'b0, {24'h055555, 6'd5, 2'd0}, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    repeat (10) @(negedge clk);
    check_val("stall_valid", bus.mem_req_valid, 1);
    check_val("stall_addr", bus.mem_addr, {24'h055555, 6'd5});
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("stall_rst");
    rst = 1'b0;
    sb.delete();
    mq.delete();
    mem_delay = 0;

    do_req(1'b0, {24'hABCDE0, 6'd0, 2'd3}, 32'h0, 32'hDEADBEEF, 1'b1, 3, 1'b0);
    wait_done();

    // replay miss: cache refuses to hit even after the refill
    force_miss = 1'b1;
    push_mem(1'b0, 24'h0BEEF0, 6'd6, '0, blk6);
    do_req(1'b0, {24'h0BEEF0, 6'd6, 2'd1}, 32'h0, 32'h0, 1'b1, 7, 1'b1);
    wait_done();
    repeat (10) @(negedge clk);
    check_val("err_sticky", bus.err, 1);
    check_val("idle_after_err", bus.cpu_req_ready, 1);
    check_val("replay_mem_drained", mq.size(), 0);
    check_val("en_exclusive", both_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
